// File: rtl/bus_pkg.sv
// Shared types and default widths for the bus slave memory endpoint.
package bus_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    // Burst command as issued by the master
    typedef struct packed {
        logic                  wr;
        logic [ADDR_W_DEF-1:0] address;
        logic [LEN_W_DEF-1:0]  length;
    } cmd_t;
endpackage

// File: rtl/bus_slave_mem_if.sv
// Command / write-beat / read-beat channels between the bus master and the slave memory.
interface bus_slave_mem_if import bus_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_wr;
    logic [ADDR_W-1:0] io_req_address;
    logic [LEN_W-1:0]  io_req_length;
    logic              io_wvalid;
    logic              io_wready;
    logic [DATA_W-1:0] io_wdata;
    logic              io_rvalid;
    logic              io_rready;
    logic [DATA_W-1:0] io_rdata;
    logic              io_done;
    logic              io_err;

    modport slave (
        input  io_req_valid, io_req_wr, io_req_address, io_req_length,
               io_wvalid, io_wdata, io_rready,
        output io_req_ready, io_wready, io_rvalid, io_rdata, io_done, io_err
    );

    modport master (
        output io_req_valid, io_req_wr, io_req_address, io_req_length,
               io_wvalid, io_wdata, io_rready,
        input  io_req_ready, io_wready, io_rvalid, io_rdata, io_done, io_err
    );
endinterface

// File: rtl/bus_mem_array.sv
// DEPTH x DATA_W register file: one write port, one registered read port,
// whole array cleared by the asynchronous active-low reset.
module bus_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,   // load zero instead of a stored word
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]            rd_data_q;

    // Storage write and read-data register load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) mem_q[wr_addr] <= wr_data;
            if (rd_en) rd_data_q <= rd_zero ? '0 : mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/bus_slave_mem.sv
// Slave memory endpoint: accepts a burst command, then moves `length` beats
// over valid/ready channels and pulses done at completion.
// Optional macro BUS_SLAVE_ERR_EN: out-of-range bursts flag io_err and do not
// wrap; without it addresses wrap modulo DEPTH and io_err stays 0.
module bus_slave_mem import bus_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic            clock,
    input  logic            reset,
    bus_slave_mem_if.slave  bus
);
    // One extra address bit so a non-wrapping burst can run past the top word
    localparam int AX_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [AX_W-1:0]   addr_q, addr_d, addr_inc;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              wready_q, wready_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
    logic              err_flag_q, err_flag_d;
    logic              err_q, err_d;
    logic              oob_cmd;
    logic              req_fire, wr_fire, rd_fire;
    logic              mem_rd_en;
    logic [AX_W-1:0]   mem_rd_addr;

    assign req_fire = bus.io_req_valid & req_ready_q;
    assign wr_fire  = bus.io_wvalid & wready_q;
    assign rd_fire  = rvalid_q & bus.io_rready;

`ifdef BUS_SLAVE_ERR_EN
    assign oob_cmd  = (32'(bus.io_req_address) + 32'(bus.io_req_length)) > 32'(DEPTH);
    assign addr_inc = addr_q + AX_W'(1);
`else
    assign oob_cmd  = 1'b0;
    assign addr_inc = {1'b0, addr_q[ADDR_W-1:0] + ADDR_W'(1)};
`endif

    // Next-state, counters and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        wready_d    = wready_q;
        rvalid_d    = rvalid_q;
        done_d      = 1'b0;
        err_flag_d  = err_flag_q;
        err_d       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = addr_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_fire) begin
                    addr_d      = {1'b0, bus.io_req_address};
                    cnt_d       = bus.io_req_length;
                    err_flag_d  = oob_cmd;
                    req_ready_d = 1'b0;
                    if (bus.io_req_length == '0) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = oob_cmd;
                    end else if (bus.io_req_wr) begin
                        state_d  = WRITE;
                        wready_d = 1'b1;
                    end else begin
                        // First read word is fetched at accept: latency 1
                        state_d     = READ;
                        rvalid_d    = 1'b1;
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = {1'b0, bus.io_req_address};
                    end
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d  = RESP;
                        wready_d = 1'b0;
                        done_d   = 1'b1;
                        err_d    = err_flag_q;
                    end
                end
            end
            READ: begin
                if (rd_fire) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d  = RESP;
                        rvalid_d = 1'b0;
                        done_d   = 1'b1;
                        err_d    = err_flag_q;
                    end else begin
                        // Prefetch next word so beats stream one per cycle
                        addr_d      = addr_inc;
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = addr_inc;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            wready_q    <= wready_d;
            rvalid_q    <= rvalid_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            err_q       <= err_d;
        end
    end

    bus_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_fire && (addr_q < AX_W'(DEPTH))),
        .wr_addr (addr_q[ADDR_W-1:0]),
        .wr_data (bus.io_wdata),
        .rd_en   (mem_rd_en),
        .rd_zero (mem_rd_addr >= AX_W'(DEPTH)),
        .rd_addr (mem_rd_addr[ADDR_W-1:0]),
        .rd_data (bus.io_rdata)
    );

    assign bus.io_req_ready = req_ready_q;
    assign bus.io_wready    = wready_q;
    assign bus.io_rvalid    = rvalid_q;
    assign bus.io_done      = done_q;
    assign bus.io_err       = err_q;
endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: directed scenarios plus random bursts, checked
// against a word-array memory model and burst-level timing expectations.
module tb_bus_slave_mem;
    import bus_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [31:0] mem_m [16];

    always #5 clock = ~clock;

    bus_slave_mem_if #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) bif ();

    bus_slave_mem #(.DATA_W(32), .ADDR_W(4), .LEN_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    function automatic logic [31:0] exp_rd(input int a);
`ifdef BUS_SLAVE_ERR_EN
        return (a >= 16) ? 32'h0 : mem_m[a];
`else
        return mem_m[a % 16];
`endif
    endfunction

    function automatic void mem_write(input int a, input logic [31:0] d);
`ifdef BUS_SLAVE_ERR_EN
        if (a < 16) mem_m[a] = d;
`else
        mem_m[a % 16] = d;
`endif
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return 1'(cyc % 2);
        return 1'b1;
    endfunction

    // One complete burst; reads compare against exp (if given) else the model.
    // abort_after >= 0 returns just after that many beats, leaving the burst open.
    task automatic burst(input bit wr, input int addr, input int len,
                         input logic [31:0] data[$], input int mode,
                         input int stall_beat, input int stall_n, input int abort_after);
        int i, cyc, stall_left;
        bit hs, err_e;
        logic [31:0] exp;
        err_e = 1'b0;
`ifdef BUS_SLAVE_ERR_EN
        err_e = (addr + len > 16);
`endif
        @(negedge clock);
        cyc = 0;
        while (bif.io_req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (bif.io_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_wait: got %b want 1", bif.io_req_ready);
            return;
        end
        bif.io_req_valid   = 1'b1;
        bif.io_req_wr      = wr;
        bif.io_req_address = 4'(addr);
        bif.io_req_length  = 4'(len);
        @(negedge clock);
        bif.io_req_valid = 1'b0;
        i = 0;
        cyc = 0;
        stall_left = stall_n;
        while (i < len && cyc < 400) begin
            checks++;
            if (bif.io_done !== 1'b0 || bif.io_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL mid_burst: got done=%b req_ready=%b want 0,0 beat %0d",
                         bif.io_done, bif.io_req_ready, i);
            end
            if (wr) begin
                checks++;
                if (bif.io_wready !== 1'b1 || bif.io_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_chan: got wready=%b rvalid=%b want 1,0 beat %0d",
                             bif.io_wready, bif.io_rvalid, i);
                end
                bif.io_wdata  = data[i];
                bif.io_wvalid = pick(mode, cyc);
                hs = bif.io_wvalid && bif.io_wready;
            end else begin
                exp = (data.size() > i) ? data[i] : exp_rd(addr + i);
                checks++;
                if (bif.io_rvalid !== 1'b1 || bif.io_wready !== 1'b0 || bif.io_rdata !== exp) begin
                    fails++;
                    $display("FAIL rd_beat: got rvalid=%b wready=%b rdata=%h want 1,0,%h beat %0d",
                             bif.io_rvalid, bif.io_wready, bif.io_rdata, exp, i);
                end
                if (i == stall_beat && stall_left > 0) begin
                    bif.io_rready = 1'b0;
                    stall_left--;
                end else begin
                    bif.io_rready = pick(mode, cyc);
                end
                hs = bif.io_rready && bif.io_rvalid;
            end
            @(posedge clock);
            if (hs) begin
                if (wr) mem_write(addr + i, data[i]);
                i++;
            end
            if (abort_after >= 0 && i == abort_after) return;
            @(negedge clock);
            cyc++;
        end
        bif.io_wvalid = 1'b0;
        bif.io_rready = 1'b0;
        checks++;
        if (i != len) begin
            fails++;
            $display("FAIL burst_timeout: got %0d beats want %0d", i, len);
            return;
        end
        checks++;
        if (bif.io_done !== 1'b1 || bif.io_err !== err_e || bif.io_wready !== 1'b0 ||
            bif.io_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got done=%b err=%b wready=%b rvalid=%b want 1,%b,0,0",
                     bif.io_done, bif.io_err, bif.io_wready, bif.io_rvalid, err_e);
        end
        @(negedge clock);
        checks++;
        if (bif.io_done !== 1'b0 || bif.io_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL after_done: got done=%b req_ready=%b want 0,1",
                     bif.io_done, bif.io_req_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (bif.io_req_ready !== 1'b0 || bif.io_wready !== 1'b0 || bif.io_rvalid !== 1'b0 ||
            bif.io_done !== 1'b0 || bif.io_err !== 1'b0 || bif.io_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got rr=%b wr=%b rv=%b d=%b e=%b rd=%h want all 0",
                     bif.io_req_ready, bif.io_wready, bif.io_rvalid, bif.io_done,
                     bif.io_err, bif.io_rdata);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bif.io_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bif.io_req_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0] q[$];
        q.delete(); q.push_back(32'hA);
        burst(1'b1, 7, 1, q, 0, -1, 0, -1);
        burst(1'b0, 7, 1, q, 0, -1, 0, -1);
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        q.delete(); q.push_back(32'h55); q.push_back(32'h66);
        burst(1'b1, 0, 2, q, 0, -1, 0, -1);
        q.delete(); q.push_back(32'h1); q.push_back(32'h2); q.push_back(32'h3); q.push_back(32'h4);
        burst(1'b1, 14, 4, q, 0, -1, 0, -1);
        q.delete(); q.push_back(32'h1); q.push_back(32'h2);
        burst(1'b0, 14, 2, q, 0, -1, 0, -1);
        q.delete();
`ifdef BUS_SLAVE_ERR_EN
        q.push_back(32'h55); q.push_back(32'h66);
`else
        q.push_back(32'h3); q.push_back(32'h4);
`endif
        burst(1'b0, 0, 2, q, 0, -1, 0, -1);
    endtask

    task automatic test_read_stall();
        logic [31:0] q[$];
        q.delete(); q.push_back(32'hC0); q.push_back(32'hC1); q.push_back(32'hC2);
        burst(1'b1, 0, 3, q, 0, -1, 0, -1);
        burst(1'b0, 0, 3, q, 0, 1, 2, -1);
    endtask

    task automatic test_len0();
        logic [31:0] q[$];
        q.delete();
        burst(1'b1, 3, 0, q, 0, -1, 0, -1);
        burst(1'b0, 9, 0, q, 0, -1, 0, -1);
        burst(1'b0, 0, 15, q, 0, -1, 0, -1);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] q[$];
        q.delete(); q.push_back(32'h11); q.push_back(32'h22); q.push_back(32'h33); q.push_back(32'h44);
        burst(1'b1, 0, 4, q, 0, -1, 0, 2);
        #2 reset = 1'b0;
        bif.io_wvalid = 1'b0;
        #1;
        checks++;
        if (bif.io_req_ready !== 1'b0 || bif.io_wready !== 1'b0 || bif.io_done !== 1'b0 ||
            bif.io_rvalid !== 1'b0 || bif.io_rdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got rr=%b wr=%b d=%b rv=%b rd=%h want all 0",
                     bif.io_req_ready, bif.io_wready, bif.io_done, bif.io_rvalid, bif.io_rdata);
        end
        for (int k = 0; k < 16; k++) mem_m[k] = 32'h0;
        @(negedge clock);
        reset = 1'b1;
        q.delete();
        burst(1'b0, 0, 15, q, 0, -1, 0, -1);
        burst(1'b0, 15, 1, q, 0, -1, 0, -1);
    endtask

    task automatic test_wvalid_gaps();
        logic [31:0] q[$];
        q.delete(); q.push_back(32'hD0); q.push_back(32'hD1); q.push_back(32'hD2); q.push_back(32'hD3);
        burst(1'b1, 5, 4, q, 2, -1, 0, -1);
        q.delete();
        burst(1'b0, 4, 6, q, 0, -1, 0, -1);
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        cmd_t c;
        for (int n = 0; n < 40; n++) begin
            c = cmd_t'($urandom);
            q.delete();
            if (c.wr) for (int k = 0; k < int'(c.length); k++) q.push_back($urandom);
            burst(c.wr, int'(c.address), int'(c.length), q, 1, -1, 0, -1);
        end
    endtask

    initial begin
        bif.io_req_valid   = 1'b0;
        bif.io_req_wr      = 1'b0;
        bif.io_req_address = '0;
        bif.io_req_length  = '0;
        bif.io_wvalid      = 1'b0;
        bif.io_wdata       = '0;
        bif.io_rready      = 1'b0;
        for (int k = 0; k < 16; k++) mem_m[k] = 32'h0;
        test_reset();
        test_single();
        test_wrap();
        test_read_stall();
        test_len0();
        test_reset_mid_burst();
        test_wvalid_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end
endmodule
